// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two writeback lanes, alloc, scoreboard.
// master drives indices/writes/alloc; slave returns data, ready and busy_vec.
interface reg_file_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic                we0;
   logic                we1;
   logic [AW-1:0]       wa0;
   logic [AW-1:0]       wa1;
   logic [XLEN-1:0]     wd0;
   logic [XLEN-1:0]     wd1;
   logic                alloc_en;
   logic [AW-1:0]       alloc_reg;
   logic [NREG-1:0]     busy_vec;

   modport master (
      output rd_addr, we0, we1, wa0, wa1,
      output wd0, wd1, alloc_en, alloc_reg,
      input  rd_data, rd_ready, busy_vec
   );

   modport slave (
      input  rd_addr, we0, we1, wa0, wa1,
      input  wd0, wd1, alloc_en, alloc_reg,
      output rd_data, rd_ready, busy_vec
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write lanes, write-to-read bypass and
// a busy scoreboard. Ports: clk, reset (sync, active-high), bus (slave).
module reg_file_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic         clk,
   input  logic         reset,
   reg_file_mp_if.slave bus
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Alloc beats writeback: a newer producer supersedes the one retiring.
   always_comb begin
      busy_nxt = '0;
      for (int i = 1; i < NREG; i++) begin
         logic set_i;
         logic clr_i;
         set_i = bus.alloc_en && (bus.alloc_reg == AW'(i));
         clr_i = (bus.we0 && (bus.wa0 == AW'(i)))
              || (bus.we1 && (bus.wa1 == AW'(i)));
         busy_nxt[i] = set_i || (busy[i] && !clr_i);
      end
   end

   // Lane 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (bus.we0 && (bus.wa0 != '0)) begin
            regs[bus.wa0] <= bus.wd0;
         end
         if (bus.we1 && (bus.wa1 != '0)) begin
            regs[bus.wa1] <= bus.wd1;
         end
         busy <= busy_nxt;
      end
   end

   // Combinational read with bypass; lane 1 has priority over lane 0.
   always_comb begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            hit0;
      logic            hit1;
      bus.rd_data  = '0;
      bus.rd_ready = '0;
      a    = '0;
      d    = '0;
      hit0 = 1'b0;
      hit1 = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         a    = bus.rd_addr[k*AW +: AW];
         hit0 = bus.we0 && (bus.wa0 == a);
         hit1 = bus.we1 && (bus.wa1 == a);
         if (a == '0) begin
            d = '0;
         end else if (hit1) begin
            d = bus.wd1;
         end else if (hit0) begin
            d = bus.wd0;
         end else begin
            d = regs[a];
         end
         bus.rd_data[k*XLEN +: XLEN] = d;
         bus.rd_ready[k] = (a == '0) || !busy[a]
                        || hit0 || hit1;
      end
   end

   assign bus.busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp in two configurations,
// checked against an array/bit-vector model of the register file.
module tb_reg_file_mp;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   reg_file_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) ia ();
   reg_file_mp_if #(.XLEN(64), .NREG(16), .NRD(3)) ib ();

   reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ia.slave)
   );

   reg_file_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ib.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cfg, nreg, nrd;
   logic [63:0] dmask;

   logic [4:0]  s_ra [3];
   logic        s_we0, s_we1, s_alloc;
   logic [4:0]  s_wa0, s_wa1, s_areg;
   logic [63:0] s_wd0, s_wd1;

   logic [63:0] mreg [32];
   bit          mbusy [32];

   always_comb begin
      ia.rd_addr   = {s_ra[1], s_ra[0]};
      ib.rd_addr   = {s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};
      ia.we0       = s_we0;
      ib.we0       = s_we0;
      ia.we1       = s_we1;
      ib.we1       = s_we1;
      ia.wa0       = s_wa0;
      ib.wa0       = s_wa0[3:0];
      ia.wa1       = s_wa1;
      ib.wa1       = s_wa1[3:0];
      ia.wd0       = s_wd0[31:0];
      ib.wd0       = s_wd0;
      ia.wd1       = s_wd1[31:0];
      ib.wd1       = s_wd1;
      ia.alloc_en  = s_alloc;
      ib.alloc_en  = s_alloc;
      ia.alloc_reg = s_areg;
      ib.alloc_reg = s_areg[3:0];
   end

   function automatic logic [63:0] exp_data(logic [4:0] a);
      if (a == 0) return 64'd0;
      if (s_we1 && s_wa1 == a) return s_wd1 & dmask;
      if (s_we0 && s_wa0 == a) return s_wd0 & dmask;
      return mreg[a];
   endfunction

   function automatic logic exp_rdy(logic [4:0] a);
      return (a == 0) || !mbusy[a]
          || (s_we0 && s_wa0 == a)
          || (s_we1 && s_wa1 == a);
   endfunction

   function automatic logic [63:0] exp_busy();
      logic [63:0] v = '0;
      for (int i = 0; i < nreg; i++) v[i] = mbusy[i];
      return v;
   endfunction

   function automatic logic [63:0] got_data(int k);
      if (cfg == 0) return {32'd0, ia.rd_data[k*32 +: 32]};
      return ib.rd_data[k*64 +: 64];
   endfunction

   function automatic logic got_rdy(int k);
      if (cfg == 0) return ia.rd_ready[k];
      return ib.rd_ready[k];
   endfunction

   function automatic logic [63:0] got_busy();
      if (cfg == 0) return {32'd0, ia.busy_vec};
      return {48'd0, ib.busy_vec};
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got %h expected %h",
                  cfg, tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < nrd; k++) begin
         chk($sformatf("rd_data[%0d] a=%0d", k, s_ra[k]),
             got_data(k), exp_data(s_ra[k]));
         chk($sformatf("rd_ready[%0d] a=%0d", k, s_ra[k]),
             64'(got_rdy(k)), 64'(exp_rdy(s_ra[k])));
      end
      chk("busy_vec", got_busy(), exp_busy());
   endtask

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
         end
         return;
      end
      if (s_we0 && s_wa0 != 0) mreg[s_wa0] = s_wd0 & dmask;
      if (s_we1 && s_wa1 != 0) mreg[s_wa1] = s_wd1 & dmask;
      for (int i = 1; i < nreg; i++) begin
         if (s_alloc && s_areg == 5'(i)) mbusy[i] = 1'b1;
         else if ((s_we0 && s_wa0 == 5'(i)) ||
                  (s_we1 && s_wa1 == 5'(i))) mbusy[i] = 1'b0;
      end
   endtask

   task automatic step(bit do_chk = 1'b1);
      #1;
      if (do_chk) check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      reset   = 1'b0;
      s_we0   = 1'b0;
      s_we1   = 1'b0;
      s_alloc = 1'b0;
   endtask

   task automatic ra_all(logic [4:0] a);
      for (int k = 0; k < 3; k++) s_ra[k] = a;
   endtask

   task automatic run_cfg(int c);
      logic [63:0] bv;
      cfg   = c;
      nreg  = (c == 0) ? 32 : 16;
      nrd   = (c == 0) ? 2 : 3;
      dmask = (c == 0) ? 64'h0000_0000_FFFF_FFFF : '1;

      idle();
      reset = 1'b1;
      step(1'b0);
      idle();
      for (int a = 0; a < nreg; a++) begin
         ra_all(5'(a));
         step();
      end

      s_we0 = 1'b1; s_wa0 = 5; s_wd0 = 64'hDEADBEEF;
      s_ra[0] = 5;
      #1 chk("bypass w0", got_data(0), 64'hDEADBEEF);
      step();
      idle();
      #1 chk("held w0", got_data(0), 64'hDEADBEEF);
      step();

      s_we0 = 1'b1; s_we1 = 1'b1; s_wa0 = 7; s_wa1 = 7;
      s_wd0 = 64'h11; s_wd1 = 64'h22; s_ra[0] = 7;
      #1 chk("dual bypass", got_data(0), 64'h22);
      step();
      idle();
      #1 chk("dual stored", got_data(0), 64'h22);
      step();
      s_we0 = 1'b1; s_we1 = 1'b1; s_wa0 = 0; s_wa1 = 0;
      s_wd0 = 64'hFF; s_wd1 = 64'hFF; s_ra[0] = 0;
      #1 chk("r0 bypass", got_data(0), 64'd0);
      step();
      idle();
      #1 chk("r0 stored", got_data(0), 64'd0);
      step();

      s_alloc = 1'b1; s_areg = 9;
      step();
      idle();
      s_ra[1] = 9;
      #1 bv = got_busy();
      chk("alloc busy9", 64'(bv[9]), 64'd1);
      chk("alloc rdy9", 64'(got_rdy(1)), 64'd0);
      step();
      s_we1 = 1'b1; s_wa1 = 9; s_wd1 = 64'h1234;
      #1 chk("wb rdy9", 64'(got_rdy(1)), 64'd1);
      chk("wb data9", got_data(1), 64'h1234);
      step();
      idle();
      #1 bv = got_busy();
      chk("cleared busy9", 64'(bv[9]), 64'd0);
      step();

      s_alloc = 1'b1; s_areg = 3;
      s_we0 = 1'b1; s_wa0 = 3; s_wd0 = 64'hABC;
      step();
      idle();
      s_ra[0] = 3;
      #1 bv = got_busy();
      chk("alloc+wb busy3", 64'(bv[3]), 64'd1);
      chk("alloc+wb data3", got_data(0), 64'hABC);
      step();
      s_alloc = 1'b1; s_areg = 0;
      step();
      idle();
      #1 bv = got_busy();
      chk("alloc r0", 64'(bv[0]), 64'd0);
      step();

      for (int r = 1; r <= 4; r++) begin
         s_we0 = 1'b1; s_wa0 = 5'(r); s_wd0 = 64'(r) * 64'h0101;
         step();
      end
      idle();
      s_alloc = 1'b1; s_areg = 2;
      step();
      s_areg = 4;
      step();
      idle();
      reset = 1'b1;
      s_we1 = 1'b1; s_wa1 = 1; s_wd1 = 64'h55;
      s_alloc = 1'b1; s_areg = 6; s_ra[0] = 1;
      #1 chk("reset bypass", got_data(0), 64'h55);
      step();
      idle();
      #1 chk("post-reset busy", got_busy(), 64'd0);
      for (int a = 0; a < nreg; a++) begin
         ra_all(5'(a));
         #1 chk("post-reset data", got_data(0), 64'd0);
         step();
      end

      repeat (300) begin
         reset   = ($urandom_range(0, 49) == 0);
         s_we0   = 1'($urandom);
         s_we1   = 1'($urandom);
         s_alloc = ($urandom_range(0, 2) == 0);
         s_wa0   = 5'($urandom_range(0, nreg - 1));
         s_wa1   = ($urandom_range(0, 3) == 0) ? s_wa0
                 : 5'($urandom_range(0, nreg - 1));
         s_areg  = 5'($urandom_range(0, nreg - 1));
         s_wd0   = {$urandom, $urandom};
         s_wd1   = {$urandom, $urandom};
         for (int k = 0; k < 3; k++)
            s_ra[k] = ($urandom_range(0, 2) == 0) ? s_wa1
                    : 5'($urandom_range(0, nreg - 1));
         step();
      end
      idle();
   endtask

   initial begin
      reset   = 1'b1;
      s_we0   = 1'b0;
      s_we1   = 1'b0;
      s_alloc = 1'b0;
      s_wa0   = '0;
      s_wa1   = '0;
      s_areg  = '0;
      s_wd0   = '0;
      s_wd1   = '0;
      ra_all(5'd0);
      @(negedge clk);
      run_cfg(0);
      run_cfg(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
